softmax_argmax_seq: RTL

//  Downstream consumer of the Softmax stage: takes one packed vector of SIZE IEEE-754

---
 rtl/softmax_argmax_seq.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/softmax_argmax_seq.sv
// -----------------------------------------------------------------------------
// softmax_argmax_seq
//   Classifier output stage. Accepts one packed vector of SIZE IEEE-754 single
//   precision probabilities and scans it one element per clock. It returns the
//   index and value of the largest element.
//   The float ordering is pure bit logic with no FP unit:
//     - NaN never wins.
//     - +0 equals -0.
//     - Ties keep the lowest index.
//
// Optional feature: define SOFTMAX_ARGMAX_THRESHOLD_EN to add the threshold
// input and the low_conf output. low_conf flags a winner that is NaN or not
// above threshold.
//
// Ports
//   clk        in   1         rising-edge clock
//   rst_n      in   1         asynchronous active-low reset
//   in_valid   in   1         'in' carries a vector
//   in_ready   out  1         block can accept a vector (IDLE only)
//   in         in   32*SIZE   packed floats, element i at in[32*i +: 32]
//   threshold  in   32        (THRESHOLD_EN) confidence threshold, sampled on accept
//   low_conf   out  1         (THRESHOLD_EN) winner is NaN or not above threshold
//   out_valid  out  1         class_idx/max_value valid
//   out_ready  in   1         downstream consumes the result
//   class_idx  out  IDX_W     index of the maximum element
//   max_value  out  32        value of the maximum element
// -----------------------------------------------------------------------------
module softmax_argmax_seq #(
  parameter  int unsigned SIZE  = 4,
  localparam int unsigned IDX_W = $clog2(SIZE)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [32*SIZE-1:0] in,
`ifdef SOFTMAX_ARGMAX_THRESHOLD_EN
  input  logic [31:0]        threshold,
  output logic               low_conf,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   class_idx,
  output logic [31:0]        max_value
);

  localparam int unsigned VEC_W = 32 * SIZE;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // NaN: all-ones exponent with a non-zero mantissa.
  function automatic logic f_is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
  endfunction

  // Returns a > b. A non-NaN always beats a NaN, so a NaN seed gets replaced.
  function automatic logic f_gt(input logic [31:0] a, input logic [31:0] b);
    logic a_zero;
    logic b_zero;
    a_zero = (a[30:0] == 31'd0);
    b_zero = (b[30:0] == 31'd0);
    if (f_is_nan(a))      return 1'b0;
    if (f_is_nan(b))      return 1'b1;
    if (a_zero && b_zero) return 1'b0;
    if (a[31] != b[31])   return ~a[31];
    if (!a[31])           return a[30:0] > b[30:0];
    return a[30:0] < b[30:0];
  endfunction

  state_t             r_state,      nxt_state;
  logic [VEC_W-1:0]   r_vec,        nxt_vec;
  logic [31:0]        r_best,       nxt_best;
  logic [IDX_W-1:0]   r_best_idx,   nxt_best_idx;
  logic [IDX_W-1:0]   r_i,          nxt_i;
  logic               r_in_ready,   nxt_in_ready;
  logic               r_out_valid,  nxt_out_valid;
  logic [IDX_W-1:0]   r_class_idx,  nxt_class_idx;
  logic [31:0]        r_max_value,  nxt_max_value;
`ifdef SOFTMAX_ARGMAX_THRESHOLD_EN
  logic [31:0]        r_thr,        nxt_thr;
  logic               r_low_conf,   nxt_low_conf;
  logic               w_low;
`endif

  logic [31:0]        w_elem;
  logic               w_upd;
  logic               w_last;
  logic [31:0]        w_fin_max;
  logic [IDX_W-1:0]   w_fin_idx;

  // Element selected by the scan counter.
  always_comb begin
    w_elem = 32'd0;
    for (int k = 0; k < SIZE; k++) begin
      if (r_i == IDX_W'(k)) w_elem = r_vec[32*k +: 32];
    end
  end

  // The result includes the final compare, so it is ready on the last SCAN edge.
  assign w_upd     = f_gt(w_elem, r_best);
  assign w_last    = (r_i == IDX_W'(SIZE - 1));
  assign w_fin_max = w_upd ? w_elem : r_best;
  assign w_fin_idx = w_upd ? r_i    : r_best_idx;
`ifdef SOFTMAX_ARGMAX_THRESHOLD_EN
  assign w_low     = f_is_nan(w_fin_max) || !f_gt(w_fin_max, r_thr);
`endif

  // Next-state and next-output logic.
  always_comb begin
    nxt_state     = r_state;
    nxt_vec       = r_vec;
    nxt_best      = r_best;
    nxt_best_idx  = r_best_idx;
    nxt_i         = r_i;
    nxt_in_ready  = r_in_ready;
    nxt_out_valid = r_out_valid;
    nxt_class_idx = r_class_idx;
    nxt_max_value = r_max_value;
`ifdef SOFTMAX_ARGMAX_THRESHOLD_EN
    nxt_thr       = r_thr;
    nxt_low_conf  = r_low_conf;
`endif

    case (r_state)
      S_IDLE: begin
        if (in_valid && r_in_ready) begin
          nxt_vec      = in;
          nxt_best     = in[31:0];
          nxt_best_idx = '0;
          nxt_i        = IDX_W'(1);
          nxt_in_ready = 1'b0;
`ifdef SOFTMAX_ARGMAX_THRESHOLD_EN
          nxt_thr      = threshold;
`endif
          nxt_state    = S_SCAN;
        end
      end

      S_SCAN: begin
        nxt_best     = w_fin_max;
        nxt_best_idx = w_fin_idx;
        nxt_i        = r_i + IDX_W'(1);
        if (w_last) begin
          nxt_i         = '0;
          nxt_out_valid = 1'b1;
          nxt_class_idx = w_fin_idx;
          nxt_max_value = w_fin_max;
`ifdef SOFTMAX_ARGMAX_THRESHOLD_EN
          nxt_low_conf  = w_low;
`endif
          nxt_state     = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          nxt_out_valid = 1'b0;
          nxt_in_ready  = 1'b1;
`ifdef SOFTMAX_ARGMAX_THRESHOLD_EN
          nxt_low_conf  = 1'b0;
`endif
          nxt_state     = S_IDLE;
        end
      end

      default: begin
        nxt_out_valid = 1'b0;
        nxt_in_ready  = 1'b1;
        nxt_state     = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_vec       <= '0;
      r_best      <= 32'd0;
      r_best_idx  <= '0;
      r_i         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_class_idx <= '0;
      r_max_value <= 32'd0;
`ifdef SOFTMAX_ARGMAX_THRESHOLD_EN
      r_thr       <= 32'd0;
      r_low_conf  <= 1'b0;
`endif
    end else begin
      r_state     <= nxt_state;
      r_vec       <= nxt_vec;
      r_best      <= nxt_best;
      r_best_idx  <= nxt_best_idx;
      r_i         <= nxt_i;
      r_in_ready  <= nxt_in_ready;
      r_out_valid <= nxt_out_valid;
      r_class_idx <= nxt_class_idx;
      r_max_value <= nxt_max_value;
`ifdef SOFTMAX_ARGMAX_THRESHOLD_EN
      r_thr       <= nxt_thr;
      r_low_conf  <= nxt_low_conf;
`endif
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign class_idx = r_class_idx;
  assign max_value = r_max_value;
`ifdef SOFTMAX_ARGMAX_THRESHOLD_EN
  assign low_conf  = r_low_conf;
`endif

endmodule
